datapath_controller: RTL

Instruction sequencer for the RISC datapath. It latches a 16-bit instruction on a start request, decodes it, and drives the register-file, operand, ALU, shift and status-load controls of the computation stage over several cycles, then signals completion. It sits between the instruction source and the datapath, and is the only block that asserts `loada`, `loadb`, `loadc`, `loads` and `write`.

---
 rtl/datapath_controller_if.sv | 33 +++
 rtl/datapath_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/datapath_controller_if.sv
// Instruction-source and datapath control bundle for the datapath controller.
// The master side is the controller; the slave side is the source/datapath.
interface datapath_controller_if;
    logic        s;
    logic [15:0] in;
    logic        w;
    logic        err;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic        loadc;
    logic        loads;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;

    modport master (
        input  s, in,
        output w, err, readnum, writenum, write, vsel, loada, loadb,
               asel, bsel, loadc, loads, shift, ALUop, sximm8
    );

    modport slave (
        output s, in,
        input  w, err, readnum, writenum, write, vsel, loada, loadb,
               asel, bsel, loadc, loads, shift, ALUop, sximm8
    );
endinterface

// File: rtl/datapath_controller.sv
// Multi-cycle instruction sequencer: latches an instruction, decodes it and
// steps the datapath through operand fetch, execute and writeback.
module datapath_controller (
    input  logic                  clk,
    input  logic                  reset,
    datapath_controller_if.master bus
);

    typedef enum logic [2:0] {
        StWait, StDecode, StWriteImm, StGetA, StGetB, StExec, StWriteReg
    } state_e;

    typedef enum logic [2:0] {
        InsMovImm, InsMovReg, InsAlu, InsCmp, InsMvn, InsBad
    } ins_e;

    function automatic ins_e decode(input logic [15:0] ir);
        ins_e cls;
        case ({ir[15:13], ir[12:11]})
            5'b110_10:            cls = InsMovImm;
            5'b110_00:            cls = InsMovReg;
            5'b101_00, 5'b101_10: cls = InsAlu;
            5'b101_01:            cls = InsCmp;
            5'b101_11:            cls = InsMvn;
            default:              cls = InsBad;
        endcase
        return cls;
    endfunction

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ins_e        ins_q, ins_d;

    logic       w_q, w_d;
    logic       err_q, err_d;
    logic       write_q, write_d;
    logic [1:0] vsel_q, vsel_d;
    logic       loada_q, loada_d;
    logic       loadb_q, loadb_d;
    logic       asel_q, asel_d;
    logic       loadc_q, loadc_d;
    logic       loads_q, loads_d;
    logic [2:0] readnum_q, readnum_d;
    logic [2:0] writenum_q, writenum_d;
    logic [1:0] aluop_q, aluop_d;

    assign ins_q = decode(ir_q);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            StWait: begin
                if (bus.s) begin
                    ir_d    = bus.in;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (ins_q)
                    InsMovImm:           state_d = StWriteImm;
                    InsMovReg, InsMvn:   state_d = StGetB;
                    InsAlu, InsCmp:      state_d = StGetA;
                    default:             state_d = StWait;
                endcase
            end
            StWriteImm: state_d = StWait;
            StGetA:     state_d = StGetB;
            StGetB:     state_d = StExec;
            StExec:     state_d = (ins_q == InsCmp) ? StWait : StWriteReg;
            StWriteReg: state_d = StWait;
            default:    state_d = StWait;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    assign ins_d = decode(ir_d);

    always_comb begin
        w_d        = (state_d == StWait);
        err_d      = (state_d == StDecode) && (ins_d == InsBad);
        write_d    = (state_d == StWriteImm) || (state_d == StWriteReg);
        vsel_d     = (state_d == StWriteImm) ? 2'b01 : 2'b00;
        loada_d    = (state_d == StGetA);
        loadb_d    = (state_d == StGetB);
        asel_d     = (state_d == StExec) && (ins_d != InsMovReg);
        loadc_d    = (state_d == StExec) && (ins_d != InsCmp);
        loads_d    = (state_d == StExec) && (ins_d == InsCmp);
        readnum_d  = (state_d == StGetA) ? ir_d[10:8] : ir_d[2:0];
        writenum_d = (state_d == StWriteImm) ? ir_d[10:8] : ir_d[7:5];
        aluop_d    = (ins_d == InsMovReg) ? 2'b00 : ir_d[12:11];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StWait;
            ir_q       <= '0;
            w_q        <= 1'b1;
            err_q      <= 1'b0;
            write_q    <= 1'b0;
            vsel_q     <= 2'b00;
            loada_q    <= 1'b0;
            loadb_q    <= 1'b0;
            asel_q     <= 1'b0;
            loadc_q    <= 1'b0;
            loads_q    <= 1'b0;
            readnum_q  <= '0;
            writenum_q <= '0;
            aluop_q    <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            w_q        <= w_d;
            err_q      <= err_d;
            write_q    <= write_d;
            vsel_q     <= vsel_d;
            loada_q    <= loada_d;
            loadb_q    <= loadb_d;
            asel_q     <= asel_d;
            loadc_q    <= loadc_d;
            loads_q    <= loads_d;
            readnum_q  <= readnum_d;
            writenum_q <= writenum_d;
            aluop_q    <= aluop_d;
        end
    end

    assign bus.w        = w_q;
    assign bus.err      = err_q;
    assign bus.write    = write_q;
    assign bus.vsel     = vsel_q;
    assign bus.loada    = loada_q;
    assign bus.loadb    = loadb_q;
    assign bus.asel     = asel_q;
    assign bus.bsel     = 1'b0;
    assign bus.loadc    = loadc_q;
    assign bus.loads    = loads_q;
    assign bus.readnum  = readnum_q;
    assign bus.writenum = writenum_q;
    assign bus.ALUop    = aluop_q;
    assign bus.shift    = ir_q[4:3];
    assign bus.sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule
